pe_diag_ifmap_receiver: RTL

// - PE-side receiving end of the diagonal ifmap bus: snoops every DIAGONAL_BUS_PACKET, keeps those whose

---
 rtl/pe_diag_ifmap_receiver_pkg.sv | 20 ++
 rtl/pe_diag_ifmap_receiver_fifo.sv | 46 ++++
 rtl/pe_diag_ifmap_receiver.sv | 98 +++++++++
 3 files changed

// File: rtl/pe_diag_ifmap_receiver_pkg.sv
// pe_diag_ifmap_receiver_pkg: diagonal ifmap bus packet format and shared constants.
package pe_diag_ifmap_receiver_pkg;
    localparam int NUM_DIAG = 12;
    localparam int DATA_W   = 8;
    localparam int DIAG_W   = $clog2(NUM_DIAG);

    typedef struct packed {
        logic                valid;
        logic [NUM_DIAG-1:0] diag_mask;
        logic                last;
        logic [DATA_W-1:0]   data;
    } diagonal_bus_packet_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
endpackage

// File: rtl/pe_diag_ifmap_receiver_fifo.sv
// pe_ifmap_fifo: synchronous {last,data} FIFO with clear; head is visible combinationally.
module pe_ifmap_fifo
    import pe_diag_ifmap_receiver_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  fifo_entry_t              i_wdata,
    output fifo_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    // When full, a simultaneous pop frees the slot at r_rd_ptr == r_wr_ptr; the head is read before the write lands.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
endmodule

// File: rtl/pe_diag_ifmap_receiver.sv
// pe_diag_ifmap_receiver: snoops the diagonal ifmap bus, buffers packets for this PE's diagonal,
// and presents them to the MAC with one cycle of read latency plus back-pressure and overflow flags.
module pe_diag_ifmap_receiver
    import pe_diag_ifmap_receiver_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_start_conv,
    input  logic                 i_flush,
    input  logic [DIAG_W-1:0]    i_diag_id_in,
    input  diagonal_bus_packet_t i_diagonal_bus_packet,
    input  logic                 i_rd_en,
    output logic [DATA_W-1:0]    o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_rd_last,
    output logic                 o_row_done,
    output logic                 o_pe_full,
    output logic                 o_overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t              r_state;
    logic [DIAG_W-1:0]   r_diag_id;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;
    logic                r_rd_last;
    logic                r_row_done;
    logic                r_overflow;
    logic                w_active;
    logic                w_clear;
    logic                w_hit;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    fifo_entry_t         w_head;
    fifo_entry_t         w_wdata;
    logic [CW-1:0]       w_count;

    assign w_active = (r_state == ST_ACTIVE);
    assign w_clear  = i_start | i_flush;
    assign w_hit    = w_active & i_diagonal_bus_packet.valid & i_diagonal_bus_packet.diag_mask[r_diag_id];
    assign w_pop    = w_active & i_rd_en & (w_count != '0) & ~w_clear;
    assign w_push   = w_hit & ~w_clear & ((w_count != CW'(DEPTH)) | w_pop);
    assign w_drop   = w_hit & ~w_clear & (w_count == CW'(DEPTH)) & ~w_pop;
    assign w_wdata  = '{last: i_diagonal_bus_packet.last, data: i_diagonal_bus_packet.data};

    pe_ifmap_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_diag_id  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_row_done <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            r_row_done <= w_pop & w_head.last;
            if (w_pop) begin
                r_rd_data <= w_head.data;
                r_rd_last <= w_head.last;
            end
            if (i_start) begin
                r_state    <= ST_IDLE;
                r_diag_id  <= i_diag_id_in;
                r_overflow <= 1'b0;
            end else if (i_flush) begin
                r_state <= ST_IDLE;
            end else begin
                if (i_start_conv) r_state <= ST_ACTIVE;
                if (w_drop) r_overflow <= 1'b1;
            end
        end
    end

    // Margin below DEPTH absorbs the packets the NOC still sends before it sees back-pressure.
    assign o_pe_full  = w_active & (w_count >= CW'(DEPTH - FULL_MARGIN));
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_last  = r_rd_last;
    assign o_row_done = r_row_done;
    assign o_overflow = r_overflow;
endmodule
